// File: rtl/rob_circular.sv
// Circular reorder buffer: allocates one tag per dispatch, records out-of-order
// completions, and retires up to RET_W oldest completed entries per cycle in order.
module rob_circular #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned AREG_W    = 5,
  parameter int unsigned PREG_W    = 6,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned CMP_PORTS = 2,
  parameter int unsigned RET_W     = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        disp_valid,
  output logic                        disp_ready,
  input  logic [AREG_W-1:0]           disp_areg,
  input  logic [PREG_W-1:0]           disp_preg,
  input  logic [PREG_W-1:0]           disp_old_preg,
  input  logic [PC_W-1:0]             disp_pc,
  output logic [TAG_W-1:0]            disp_tag,
  input  logic [CMP_PORTS-1:0]        cmp_valid,
  input  logic [CMP_PORTS*TAG_W-1:0]  cmp_tag,
  output logic [RET_W-1:0]            ret_valid,
  output logic [RET_W*AREG_W-1:0]     ret_areg,
  output logic [RET_W*PREG_W-1:0]     ret_preg,
  output logic [RET_W*PREG_W-1:0]     ret_old_preg,
  output logic [RET_W*PC_W-1:0]       ret_pc,
  output logic                        full,
  output logic                        empty,
  output logic [TAG_W:0]              count
);

  // Head/tail carry an extra wrap bit above the index.
  logic [TAG_W:0]      head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic [DEPTH-1:0]    valid_q, valid_d, complete_q, complete_d;
  logic [AREG_W-1:0]   areg_q     [DEPTH];
  logic [PREG_W-1:0]   preg_q     [DEPTH];
  logic [PREG_W-1:0]   old_preg_q [DEPTH];
  logic [PC_W-1:0]     pc_q       [DEPTH];
  logic [TAG_W-1:0]    tail_idx;
  logic [TAG_W-1:0]    lane_idx   [RET_W];
  logic [TAG_W:0]      ret_num;
  logic                disp_fire;

  assign tail_idx   = tail_q[TAG_W-1:0];
  assign full       = (count_q == (TAG_W+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign disp_ready = !full;
  assign disp_tag   = tail_idx;
  assign count      = count_q;
  assign disp_fire  = disp_valid && disp_ready && !flush;

  // Entry index presented on each retire lane; wraps naturally mod DEPTH.
  always_comb begin
    for (int i = 0; i < RET_W; i++) begin
      lane_idx[i] = head_q[TAG_W-1:0] + TAG_W'(i);
    end
  end

  // Retire selection: contiguous run of valid+complete entries from head, bounded by count.
  always_comb begin
    logic run;
    run          = !flush;
    ret_valid    = '0;
    ret_num      = '0;
    ret_areg     = '0;
    ret_preg     = '0;
    ret_old_preg = '0;
    ret_pc       = '0;
    for (int i = 0; i < RET_W; i++) begin
      ret_areg[i*AREG_W +: AREG_W]     = areg_q[lane_idx[i]];
      ret_preg[i*PREG_W +: PREG_W]     = preg_q[lane_idx[i]];
      ret_old_preg[i*PREG_W +: PREG_W] = old_preg_q[lane_idx[i]];
      ret_pc[i*PC_W +: PC_W]           = pc_q[lane_idx[i]];
      if (run && ((TAG_W+1)'(i) < count_q) && valid_q[lane_idx[i]]
          && complete_q[lane_idx[i]]) begin
        ret_valid[i] = 1'b1;
        ret_num      = ret_num + (TAG_W+1)'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // Next-state for entry flags and pointers; retire clears after completion sets,
  // and dispatch only ever targets an invalid slot.
  always_comb begin
    valid_d    = valid_q;
    complete_d = complete_q;
    for (int k = 0; k < CMP_PORTS; k++) begin
      if (cmp_valid[k] && valid_q[cmp_tag[k*TAG_W +: TAG_W]]) begin
        complete_d[cmp_tag[k*TAG_W +: TAG_W]] = 1'b1;
      end
    end
    for (int i = 0; i < RET_W; i++) begin
      if (ret_valid[i]) begin
        valid_d[lane_idx[i]]    = 1'b0;
        complete_d[lane_idx[i]] = 1'b0;
      end
    end
    if (disp_fire) begin
      valid_d[tail_idx]    = 1'b1;
      complete_d[tail_idx] = 1'b0;
    end
    head_d  = head_q + ret_num;
    tail_d  = tail_q + (TAG_W+1)'(disp_fire);
    count_d = count_q + (TAG_W+1)'(disp_fire) - ret_num;
  end

  // Control state: async reset, synchronous flush squashes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      complete_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else if (flush) begin
      valid_q    <= '0;
      complete_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      complete_q <= complete_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Payload storage is written on dispatch only and never cleared.
  always_ff @(posedge clk) begin
    if (disp_fire) begin
      areg_q[tail_idx]     <= disp_areg;
      preg_q[tail_idx]     <= disp_preg;
      old_preg_q[tail_idx] <= disp_old_preg;
      pc_q[tail_idx]       <= disp_pc;
    end
  end

endmodule

// File: tb/tb_rob_circular.sv
// Directed bench for rob_circular with an in-order payload scoreboard.
module tb_rob_circular;

  localparam int DEPTH = 64;

  typedef struct packed {
    logic [4:0]  areg;
    logic [5:0]  preg;
    logic [5:0]  old_preg;
    logic [31:0] pc;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset, flush, disp_valid, disp_ready, full, empty;
  logic [4:0]  disp_areg;
  logic [5:0]  disp_preg, disp_old_preg, disp_tag;
  logic [31:0] disp_pc;
  logic [1:0]  cmp_valid, ret_valid;
  logic [11:0] cmp_tag;
  logic [9:0]  ret_areg;
  logic [11:0] ret_preg, ret_old_preg;
  logic [63:0] ret_pc;
  logic [6:0]  count;

  int     checks = 0;
  int     errors = 0;
  int     model_count = 0;
  int     model_tail = 0;
  entry_t sb[$];

  rob_circular dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_areg(disp_areg),
    .disp_preg(disp_preg), .disp_old_preg(disp_old_preg), .disp_pc(disp_pc),
    .disp_tag(disp_tag), .cmp_valid(cmp_valid), .cmp_tag(cmp_tag),
    .ret_valid(ret_valid), .ret_areg(ret_areg), .ret_preg(ret_preg),
    .ret_old_preg(ret_old_preg), .ret_pc(ret_pc),
    .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, cross the edge, update the model.
  task automatic tick();
    bit     acc;
    int     nret;
    entry_t e, got;
    #1;
    nret = 0;
    acc  = disp_valid && !flush && (model_count < DEPTH);
    chk("count", 64'(count), 64'(model_count));
    chk("disp_ready", 64'(disp_ready), 64'(model_count != DEPTH));
    if (acc) chk("disp_tag", 64'(disp_tag), 64'(model_tail % DEPTH));
    if (flush) begin
      chk("ret_valid_flush", 64'(ret_valid), 64'd0);
    end else begin
      chk("ret_thermometer", 64'(ret_valid == 2'b10), 64'd0);
      for (int i = 0; i < 2; i++) begin
        if (ret_valid[i]) begin
          nret++;
          got = '{ret_areg[i*5 +: 5], ret_preg[i*6 +: 6], ret_old_preg[i*6 +: 6],
                  ret_pc[i*32 +: 32]};
          if (sb.size() == 0) begin
            chk("ret_unexpected", 64'(ret_valid), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("ret_areg", 64'(got.areg), 64'(e.areg));
            chk("ret_preg", 64'(got.preg), 64'(e.preg));
            chk("ret_old_preg", 64'(got.old_preg), 64'(e.old_preg));
            chk("ret_pc", 64'(got.pc), 64'(e.pc));
          end
        end
      end
    end
    e = '{disp_areg, disp_preg, disp_old_preg, disp_pc};
    @(posedge clk);
    if (flush) begin
      sb.delete();
      model_count = 0;
      model_tail  = 0;
    end else begin
      if (acc) begin
        sb.push_back(e);
        model_tail++;
      end
      model_count = model_count + int'(acc) - nret;
    end
    @(negedge clk);
    disp_valid = 1'b0;
    cmp_valid  = '0;
    flush      = 1'b0;
  endtask

  task automatic set_disp();
    disp_valid    = 1'b1;
    disp_areg     = 5'($urandom_range(0, 31));
    disp_preg     = 6'($urandom);
    disp_old_preg = 6'($urandom);
    disp_pc       = $urandom;
  endtask

  task automatic disp();
    set_disp();
    tick();
  endtask

  task automatic cmp(input int t0, input int t1);
    cmp_valid = 2'b11;
    cmp_tag   = {6'(t1), 6'(t0)};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ret_valid", 64'(ret_valid), 64'd0);
    chk("rst_disp_tag", 64'(disp_tag), 64'd0);
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    model_count = 0;
    model_tail  = 0;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; disp_valid = 1'b0; cmp_valid = '0; cmp_tag = '0;
    disp_areg = '0; disp_preg = '0; disp_old_preg = '0; disp_pc = '0;
    @(negedge clk);
    do_reset();

    // Reset with five live entries.
    for (int i = 0; i < 5; i++) disp();
    chk("live5_count", 64'(count), 64'd5);
    do_reset();

    // Out-of-order completion, in-order retire.
    for (int i = 0; i < 3; i++) disp();
    cmp_valid = 2'b01; cmp_tag = 12'd2; tick();
    cmp_valid = 2'b01; cmp_tag = 12'd0; tick();
    #1 chk("ooo_ret_tag0", 64'(ret_valid), 64'b01);
    tick();
    chk("ooo_after_tag0", 64'(ret_valid), 64'b00);
    cmp_valid = 2'b01; cmp_tag = 12'd1; tick();
    #1 chk("ooo_ret_tag12", 64'(ret_valid), 64'b11);
    tick();
    chk("ooo_empty", 64'(empty), 64'd1);

    // Fill to full, dropped 65th dispatch, retire tag 0 while full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) disp();
    #1 chk("full_flag", 64'(full), 64'd1);
    chk("full_ready", 64'(disp_ready), 64'd0);
    disp();
    cmp_valid = 2'b01; cmp_tag = 12'd0; tick();
    set_disp();
    #1 chk("full_ret_tag0", 64'(ret_valid), 64'b01);
    tick();
    #1 chk("full_ready_after", 64'(disp_ready), 64'd1);
    chk("full_count_63", 64'(count), 64'd63);

    // Drain tags 1..61 so head reaches 62, then retire across the wrap.
    for (int t = 1; t <= 61; t += 2) begin
      cmp(t, (t + 1 <= 61) ? t + 1 : t);
      tick();
    end
    idle(5);
    chk("wrap_count2", 64'(count), 64'd2);
    disp();
    cmp(63, 0); tick();
    cmp_valid = 2'b01; cmp_tag = 12'd62; tick();
    #1 chk("wrap_ret_62_63", 64'(ret_valid), 64'b11);
    tick();
    #1 chk("wrap_ret_0", 64'(ret_valid), 64'b01);
    tick();
    chk("wrap_empty", 64'(empty), 64'd1);
    chk("wrap_disp_tag", 64'(disp_tag), 64'd1);

    // Duplicate completion on tag 5; completion to not-yet-valid tag 9 ignored.
    for (int i = 0; i < 6; i++) disp();
    cmp(5, 5); tick();
    cmp(9, 9); tick();
    for (int i = 0; i < 3; i++) disp();
    chk("dup_no_early_ret", 64'(ret_valid), 64'b00);
    cmp(1, 2); tick();
    cmp(3, 4);
    #1 chk("dup_ret_1_2", 64'(ret_valid), 64'b11);
    tick();
    #1 chk("dup_ret_3_4", 64'(ret_valid), 64'b11);
    tick();
    #1 chk("dup_ret_5", 64'(ret_valid), 64'b01);
    tick();
    cmp(6, 7); tick();
    cmp(8, 8); tick();
    idle(4);
    chk("tag9_pending", 64'(count), 64'd1);
    chk("tag9_no_ret", 64'(ret_valid), 64'b00);
    cmp(9, 9); tick();
    idle(2);
    chk("tag9_drained", 64'(empty), 64'd1);

    // Flush beats dispatch, completion and a ready retire.
    for (int i = 0; i < 4; i++) disp();
    cmp(10, 11); tick();
    flush = 1'b1;
    set_disp();
    cmp(12, 13);
    #1 chk("flush_ret_valid", 64'(ret_valid), 64'b00);
    tick();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_disp_tag", 64'(disp_tag), 64'd0);
    disp();
    idle(2);
    chk("flush_no_stale_ret", 64'(count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
